// File: rtl/spi_rx_deserializer_if.sv
// rtl/spi_rx_deserializer_if.sv - received-word stream between the deserializer and its consumer
// The deserializer drives the master side; the consumer owns rx_ready.
interface spi_rx_deserializer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/spi_rx_deserializer.sv
// rtl/spi_rx_deserializer.sv - SPI MISO deserializer, 8/16/24/32-bit words, MSB- or LSB-first
// Optional macro SPI_RX_OVERRUN_EN: keep the unconsumed word and flag rx_overrun instead of overwriting.
module spi_rx_deserializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             SPI_DATA_LEN,
  input  logic                   SPI_BIT_ORDER,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sample_en,
  input  logic                   spi_miso,
  output logic                   busy,
  output logic                   rx_overrun,
  spi_rx_deserializer_if.master  rx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [1:0]            len_q, len_d;
  logic                  order_q, order_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  ovr_q, ovr_d;

  logic [DATA_WIDTH-1:0] captured;
  logic [5:0]            cnt_inc;
  logic [5:0]            nbits;
  logic                  handshake;

  // Shift register is cleared at start, so bits above the word length are already zero.
  always_comb begin
    captured = {shreg_q[DATA_WIDTH-2:0], spi_miso};
    if (order_q) begin
      captured              = shreg_q;
      captured[cnt_q[4:0]] = spi_miso;
    end
  end

  assign cnt_inc   = cnt_q + 6'd1;
  assign nbits     = {1'b0, len_q, 3'b000} + 6'd8;
  assign handshake = rx_valid_q & rx.rx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    len_d      = len_q;
    order_d    = order_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;

    if (handshake) begin
      rx_valid_d = 1'b0;
      ovr_d      = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (abort) begin
          cnt_d = 6'd0;
        end else if (start) begin
          len_d   = SPI_DATA_LEN;
          order_d = SPI_BIT_ORDER;
          shreg_d = '0;
          cnt_d   = 6'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_d   = 6'd0;
          state_d = IDLE;
        end else if (sample_en) begin
          shreg_d = captured;
          cnt_d   = cnt_inc;
          if (cnt_inc == nbits) begin
            state_d = IDLE;
`ifdef SPI_RX_OVERRUN_EN
            if (rx_valid_q && !rx.rx_ready) begin
              ovr_d = 1'b1;
            end else begin
              rx_data_d  = captured;
              rx_valid_d = 1'b1;
            end
`else
            rx_data_d  = captured;
            rx_valid_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifndef SPI_RX_OVERRUN_EN
    ovr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      shreg_q    <= '0;
      len_q      <= 2'b00;
      order_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      len_q      <= len_d;
      order_q    <= order_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign rx_overrun  = ovr_q;
  assign rx.rx_data  = rx_data_q;
  assign rx.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// tb/tb_spi_rx_deserializer.sv - scoreboard bench for spi_rx_deserializer
// Stimulus pushes expected words; the monitor pops them on each rx_valid&rx_ready handshake.
module tb_spi_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] SPI_DATA_LEN;
  logic       SPI_BIT_ORDER;
  logic       start;
  logic       abort;
  logic       sample_en;
  logic       spi_miso;
  logic       busy;
  logic       rx_overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];

  spi_rx_deserializer_if #(.DATA_WIDTH(32)) rx_if ();

  spi_rx_deserializer #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .SPI_DATA_LEN  (SPI_DATA_LEN),
    .SPI_BIT_ORDER (SPI_BIT_ORDER),
    .start         (start),
    .abort         (abort),
    .sample_en     (sample_en),
    .spi_miso      (spi_miso),
    .busy          (busy),
    .rx_overrun    (rx_overrun),
    .rx            (rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_if.rx_valid && rx_if.rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h expected none", rx_if.rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_rx_data", rx_if.rx_data, e.data);
        chk("mon_rx_overrun", {31'd0, rx_overrun}, {31'd0, e.ovr});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start cycle also carries a sample strobe that must be ignored; inputs are scrambled afterwards
  task automatic begin_word(input logic [1:0] len, input logic ord);
    SPI_DATA_LEN  = len;
    SPI_BIT_ORDER = ord;
    start         = 1'b1;
    sample_en     = 1'b1;
    spi_miso      = 1'b1;
    step();
    start         = 1'b0;
    sample_en     = 1'b0;
    SPI_DATA_LEN  = ~len;
    SPI_BIT_ORDER = ~ord;
  endtask

  task automatic sample_bit(input logic b);
    spi_miso  = b;
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  task automatic send_word(input string name, input logic [1:0] len, input logic ord,
                           input logic [31:0] val);
    int n;
    n = (int'(len) + 1) * 8;
    begin_word(len, ord);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk({name, "_busy_before_last"}, {31'd0, busy}, 32'd1);
      sample_bit(ord ? val[i] : val[n-1-i]);
      if (i != n - 1) step();
    end
    chk({name, "_valid_at_last"}, {31'd0, rx_if.rx_valid}, 32'd1);
    chk({name, "_busy_at_last"}, {31'd0, busy}, 32'd0);
    step();
  endtask

  task automatic push(input logic [31:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovr  = o;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] partial;
    rst             = 1'b1;
    SPI_DATA_LEN    = 2'b00;
    SPI_BIT_ORDER   = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    sample_en       = 1'b0;
    spi_miso        = 1'b0;
    rx_if.rx_ready  = 1'b0;
    repeat (3) step();
    chk("rst_rx_data", rx_if.rx_data, 32'h0);
    chk("rst_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    rst            = 1'b0;
    rx_if.rx_ready = 1'b1;
    step();

    push(32'h0000_0080, 1'b0);
    send_word("len8_msb", 2'b00, 1'b0, 32'h0000_0080);
    push(32'h0000_0001, 1'b0);
    send_word("len8_lsb", 2'b00, 1'b1, 32'h0000_0001);
    push(32'h0000_BEEF, 1'b0);
    send_word("len16_msb", 2'b01, 1'b0, 32'h0000_BEEF);
    push(32'hDEAD_BEEF, 1'b0);
    send_word("len32_lsb", 2'b11, 1'b1, 32'hDEAD_BEEF);
    step();

    rx_if.rx_ready = 1'b0;
    send_word("ovr_first", 2'b00, 1'b0, 32'h0000_00A5);
    send_word("ovr_second", 2'b00, 1'b0, 32'h0000_003C);
`ifdef SPI_RX_OVERRUN_EN
    chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
    chk("ovr_data_kept", rx_if.rx_data, 32'h0000_00A5);
    push(32'h0000_00A5, 1'b1);
`else
    chk("ovr_flag", {31'd0, rx_overrun}, 32'd0);
    chk("ovr_data_overwritten", rx_if.rx_data, 32'h0000_003C);
    push(32'h0000_003C, 1'b0);
`endif
    rx_if.rx_ready = 1'b1;
    step();
    step();
    chk("ovr_cleared", {31'd0, rx_overrun}, 32'd0);
    chk("ovr_valid_cleared", {31'd0, rx_if.rx_valid}, 32'd0);

    partial = 8'hFF;
    begin_word(2'b00, 1'b0);
    for (int i = 0; i < 5; i++) sample_bit(partial[i]);
    abort     = 1'b1;
    sample_en = 1'b1;
    start     = 1'b1;
    step();
    abort     = 1'b0;
    sample_en = 1'b0;
    start     = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid_unchanged", {31'd0, rx_if.rx_valid}, 32'd0);
    push(32'h0000_005A, 1'b0);
    send_word("after_abort", 2'b00, 1'b0, 32'h0000_005A);
    step();

    begin_word(2'b01, 1'b0);
    for (int i = 0; i < 12; i++) sample_bit(1'b1);
    rst = 1'b1;
    step();
    chk("midrst_rx_data", rx_if.rx_data, 32'h0);
    chk("midrst_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overrun", {31'd0, rx_overrun}, 32'd0);
    rst = 1'b0;
    step();
    push(32'h0000_1234, 1'b0);
    send_word("after_rst", 2'b01, 1'b0, 32'h0000_1234);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
